hazard_scoreboard: RTL and testbench

Per-register scoreboard that sequences the operand-forwarding network and the single register-file write port. It sits beside the decode stage. It tracks every in-flight producer (ALU, load, 5-stage multiplier) and its pipeline position. Each cycle it issues the bypass-source selects for the instruction in decode, or stalls decode on RAW, WAW or writeback-port conflicts.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_sb_entry.sv | 91 +++++++++
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: producer kinds, bypass-source
// selects and the kind-to-writeback-latency mapping.
package hazard_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MUL  = 2'd2,
        KIND_RSV  = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        BYP_NONE = 3'd0,
        BYP_EXE  = 3'd1,
        BYP_MEM  = 3'd2,
        BYP_MUL5 = 3'd3,
        BYP_WB   = 3'd4
    } byp_e;

    localparam int unsigned AGE_W   = 3;
    localparam int unsigned RES_W   = 6;
    localparam int unsigned ALU_LAT = 3;

    // Age at which a producer sits in W; the multiplier adds one W stage after M5.
    function automatic logic [AGE_W-1:0] wb_lat(input kind_e k, input int unsigned mul_lat);
        return (k == KIND_MUL) ? 3'(mul_lat + 1) : 3'(ALU_LAT);
    endfunction

    // Encoding 3 is an undefined kind and behaves as a plain ALU producer.
    function automatic kind_e norm_kind(input logic [1:0] k);
        case (k)
            2'd1:    return KIND_LOAD;
            2'd2:    return KIND_MUL;
            default: return KIND_ALU;
        endcase
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One architectural register's in-flight producer: valid/kind/age tracking
// plus the bypass source (or RAW stall) a reader of this register would get.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frz_i,
    input  logic       alloc_i,
    input  kind_e      kind_i,
    input  logic       tl_hit_i,
    output logic       valid_o,
    output logic [2:0] rem_o,
    output byp_e       byp_o,
    output logic       raw_o
);

    localparam logic [2:0] MUL_AGE = 3'(MUL_LAT);

    logic       valid_q, valid_d;
    kind_e      kind_q, kind_d;
    logic [2:0] age_q, age_d;
    logic [2:0] lat;

    assign lat = wb_lat(kind_q, MUL_LAT);

    // A new allocation overrides retirement of the previous occupant.
    always_comb begin
        valid_d = valid_q;
        kind_d  = kind_q;
        age_d   = age_q;
        if (alloc_i) begin
            valid_d = 1'b1;
            kind_d  = kind_i;
            age_d   = 3'd1;
        end else if (!frz_i && valid_q) begin
            if (age_q >= lat) begin
                valid_d = 1'b0;
            end else begin
                age_d = age_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            kind_q  <= KIND_ALU;
            age_q   <= 3'd0;
        end else begin
            valid_q <= valid_d;
            kind_q  <= kind_d;
            age_q   <= age_d;
        end
    end

    always_comb begin
        byp_o = BYP_NONE;
        raw_o = 1'b0;
        if (valid_q) begin
            case (kind_q)
                KIND_LOAD: begin
                    if (age_q == 3'd1) begin
                        raw_o = 1'b1;
                    end else if (age_q == 3'd2) begin
                        if (tl_hit_i) byp_o = BYP_MEM;
                        else          raw_o = 1'b1;
                    end else begin
                        byp_o = BYP_WB;
                    end
                end
                KIND_MUL: begin
                    if (age_q < MUL_AGE)       raw_o = 1'b1;
                    else if (age_q == MUL_AGE) byp_o = BYP_MUL5;
                    else                       byp_o = BYP_WB;
                end
                default: begin
                    if (age_q == 3'd1)      byp_o = BYP_EXE;
                    else if (age_q == 3'd2) byp_o = BYP_MEM;
                    else                    byp_o = BYP_WB;
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign rem_o   = lat - age_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: bypass selects, RAW/WAW/writeback-port stalls.
// Optional stall statistics counters are built when HAZARD_SB_STATS_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    input  logic [1:0]  dec_kind_i,
    input  logic        dec_wr_en_i,
    input  logic [4:0]  dec_rd_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic        dec_rs1_used_i,
    input  logic        dec_rs2_used_i,
    input  logic        tl_hit_i,
    input  logic        mem_stall_i,
    output logic        stall_o,
    output logic [2:0]  byp_sel_a_o,
    output logic [2:0]  byp_sel_b_o
`ifdef HAZARD_SB_STATS_EN
    ,
    output logic [31:0] raw_stall_cnt_o,
    output logic [31:0] res_stall_cnt_o
`endif
);

    kind_e            kind_n;
    logic [2:0]       lat_new;
    logic             ent_valid [NREG];
    logic [2:0]       ent_rem   [NREG];
    byp_e             ent_byp   [NREG];
    logic             ent_raw   [NREG];
    logic [NREG-1:0]  alloc;

    logic [RES_W-1:0] res_q, res_d;
    logic [RES_W:0]   res_ext;

    byp_e sel_a, sel_b;
    logic raw_a, raw_b, raw, waw, res_hit, wr, issue;

    assign kind_n  = norm_kind(dec_kind_i);
    assign lat_new = wb_lat(kind_n, MUL_LAT);

    // x0 is hardwired: never valid, never a bypass source.
    assign ent_valid[0] = 1'b0;
    assign ent_rem[0]   = 3'd0;
    assign ent_byp[0]   = BYP_NONE;
    assign ent_raw[0]   = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        hazard_sb_entry #(.MUL_LAT(MUL_LAT)) u_ent (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .frz_i    (mem_stall_i),
            .alloc_i  (alloc[r]),
            .kind_i   (kind_n),
            .tl_hit_i (tl_hit_i),
            .valid_o  (ent_valid[r]),
            .rem_o    (ent_rem[r]),
            .byp_o    (ent_byp[r]),
            .raw_o    (ent_raw[r])
        );
    end

    always_comb begin
        sel_a = BYP_NONE;
        raw_a = 1'b0;
        sel_b = BYP_NONE;
        raw_b = 1'b0;
        if (dec_rs1_used_i && dec_rs1_i != 5'd0) begin
            sel_a = ent_byp[dec_rs1_i];
            raw_a = ent_raw[dec_rs1_i];
        end
        if (dec_rs2_used_i && dec_rs2_i != 5'd0) begin
            sel_b = ent_byp[dec_rs2_i];
            raw_b = ent_raw[dec_rs2_i];
        end
    end

    // res bit k: the single W port is already claimed k cycles from now.
    assign res_ext = {1'b0, res_q};
    assign wr      = dec_wr_en_i && (dec_rd_i != 5'd0);
    assign raw     = raw_a || raw_b;
    assign waw     = wr && ent_valid[dec_rd_i] && (ent_rem[dec_rd_i] >= lat_new);
    assign res_hit = wr && res_ext[lat_new];

    assign stall_o     = mem_stall_i || (dec_valid_i && (raw || waw || res_hit));
    assign issue       = dec_valid_i && !stall_o && wr;
    assign byp_sel_a_o = sel_a;
    assign byp_sel_b_o = sel_b;

    always_comb begin
        alloc = '0;
        if (issue) alloc[dec_rd_i] = 1'b1;
    end

    // Claim is recorded one slot lower because the vector also shifts on this edge.
    always_comb begin
        res_d = res_q;
        if (!mem_stall_i) begin
            res_d = {1'b0, res_q[RES_W-1:1]};
            if (issue) res_d = res_d | (6'd1 << (lat_new - 3'd1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) res_q <= '0;
        else       res_q <= res_d;
    end

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] raw_cnt_q, res_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_cnt_q <= 32'd0;
            res_cnt_q <= 32'd0;
        end else if (!mem_stall_i && dec_valid_i) begin
            if (raw)                        raw_cnt_q <= raw_cnt_q + 32'd1;
            if (!raw && (waw || res_hit))   res_cnt_q <= res_cnt_q + 32'd1;
        end
    end

    assign raw_stall_cnt_o = raw_cnt_q;
    assign res_stall_cnt_o = res_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes expectations from a
// tick-based reference model; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic [1:0]  dec_kind_i;
    logic        dec_wr_en_i;
    logic [4:0]  dec_rd_i, dec_rs1_i, dec_rs2_i;
    logic        dec_rs1_used_i, dec_rs2_used_i;
    logic        tl_hit_i;
    logic        mem_stall_i;
    logic        stall_o;
    logic [2:0]  byp_sel_a_o, byp_sel_b_o;
`ifdef HAZARD_SB_STATS_EN
    logic [31:0] raw_stall_cnt_o, res_stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(.NREG(32), .MUL_LAT(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dec_valid_i    (dec_valid_i),
        .dec_kind_i     (dec_kind_i),
        .dec_wr_en_i    (dec_wr_en_i),
        .dec_rd_i       (dec_rd_i),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_rs1_used_i (dec_rs1_used_i),
        .dec_rs2_used_i (dec_rs2_used_i),
        .tl_hit_i       (tl_hit_i),
        .mem_stall_i    (mem_stall_i),
        .stall_o        (stall_o),
        .byp_sel_a_o    (byp_sel_a_o),
        .byp_sel_b_o    (byp_sel_b_o)
`ifdef HAZARD_SB_STATS_EN
        ,
        .raw_stall_cnt_o(raw_stall_cnt_o),
        .res_stall_cnt_o(res_stall_cnt_o)
`endif
    );

    typedef struct {
        bit          stall;
        bit          chk_sel;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [31:0] rc;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: "now" counts non-frozen cycles; a producer issued at
    // tick T has age now-T and writes back at tick T+L.
    bit   m_has  [32];
    int   m_iss  [32];
    int   m_kind [32];
    int   m_wb   [32];
    int   wbq[$];
    int   now = 0;
    int   m_rc = 0, m_sc = 0;
    bit   known = 0;

    function automatic int lat_of(input int k);
        return (k == 2) ? 6 : 3;
    endfunction

    function automatic bit live(input int r);
        return m_has[r] && (now - m_iss[r] <= lat_of(m_kind[r]));
    endfunction

    function automatic void resolve(input int rs, input bit used, input bit hit,
                                    output int sel, output bit raw);
        int age;
        sel = 0;
        raw = 0;
        if (!used || rs == 0 || !live(rs)) return;
        age = now - m_iss[rs];
        if (m_kind[rs] == 1) begin
            if (age == 1)      raw = 1;
            else if (age == 2) begin if (hit) sel = 2; else raw = 1; end
            else               sel = 4;
        end else if (m_kind[rs] == 2) begin
            if (age <= 4)      raw = 1;
            else if (age == 5) sel = 3;
            else               sel = 4;
        end else begin
            sel = (age == 1) ? 1 : (age == 2) ? 2 : 4;
        end
    endfunction

    task automatic step(input bit v, input int k, input bit w, input int rd,
                        input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit hit, input bit ms, input bit r);
        exp_t e;
        int   s1, s2, kn, ln;
        bit   r1, r2, waw, rsv, stall, iss;
        dec_valid_i    = v;
        dec_kind_i     = 2'(k);
        dec_wr_en_i    = w;
        dec_rd_i       = 5'(rd);
        dec_rs1_i      = 5'(rs1);
        dec_rs2_i      = 5'(rs2);
        dec_rs1_used_i = u1;
        dec_rs2_used_i = u2;
        tl_hit_i       = hit;
        mem_stall_i    = ms;
        rst_i          = r;
        kn  = (k == 3) ? 0 : k;
        ln  = lat_of(kn);
        resolve(rs1, u1, hit, s1, r1);
        resolve(rs2, u2, hit, s2, r2);
        waw = w && rd != 0 && live(rd) && (m_wb[rd] - now >= ln);
        rsv = 0;
        if (w && rd != 0)
            foreach (wbq[i]) if (wbq[i] == now + ln) rsv = 1;
        stall = ms || (v && (r1 || r2 || waw || rsv));
        iss   = v && !stall && w && rd != 0;
        if (known) begin
            e.stall   = stall;
            e.chk_sel = !stall;
            e.a       = 3'(s1);
            e.b       = 3'(s2);
            e.rc      = 32'(m_rc);
            e.sc      = 32'(m_sc);
            q.push_back(e);
        end
        @(posedge clk_i);
        if (r) begin
            foreach (m_has[i]) m_has[i] = 0;
            wbq.delete();
            m_rc  = 0;
            m_sc  = 0;
            known = 1;
        end else if (!ms) begin
            if (v && (r1 || r2))                m_rc++;
            if (v && !(r1 || r2) && (waw || rsv)) m_sc++;
            if (iss) begin
                m_has[rd]  = 1;
                m_iss[rd]  = now;
                m_kind[rd] = kn;
                m_wb[rd]   = now + ln;
                wbq.push_back(now + ln);
            end
            now++;
            for (int i = wbq.size() - 1; i >= 0; i--)
                if (wbq[i] < now) wbq.delete(i);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (stall_o !== e.stall) begin
                fails++;
                $display("FAIL stall_o: got %0b want %0b at %0t", stall_o, e.stall, $time);
            end
            if (e.chk_sel) begin
                tests++;
                if (byp_sel_a_o !== e.a) begin
                    fails++;
                    $display("FAIL byp_sel_a: got %0d want %0d at %0t", byp_sel_a_o, e.a, $time);
                end
                tests++;
                if (byp_sel_b_o !== e.b) begin
                    fails++;
                    $display("FAIL byp_sel_b: got %0d want %0d at %0t", byp_sel_b_o, e.b, $time);
                end
            end
`ifdef HAZARD_SB_STATS_EN
            tests++;
            if (raw_stall_cnt_o !== e.rc) begin
                fails++;
                $display("FAIL raw_cnt: got %0d want %0d at %0t", raw_stall_cnt_o, e.rc, $time);
            end
            tests++;
            if (res_stall_cnt_o !== e.sc) begin
                fails++;
                $display("FAIL res_cnt: got %0d want %0d at %0t", res_stall_cnt_o, e.sc, $time);
            end
`endif
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);

        // ALU x5 then readers at E, C, W
        step(1, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 10, 5, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
        idle(4);

        // LOAD x6: load-use stall, then MEM on hit; again with misses
        step(1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 11, 6, 0, 1, 0, 1, 0, 0);
        step(1, 0, 1, 11, 6, 0, 1, 0, 1, 0, 0);
        idle(4);
        step(1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 11, 6, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 11, 6, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 11, 6, 0, 1, 0, 0, 0, 0);
        idle(4);

        // MUL x7 with a dependent reader on rs2
        step(1, 2, 1, 7, 0, 0, 0, 0, 1, 0, 0);
        repeat (6) step(1, 0, 1, 12, 0, 7, 0, 1, 1, 0, 0);
        idle(6);

        // Writeback-port reservation, then WAW against an in-flight MUL
        step(1, 2, 1, 8, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0);
        idle(8);
        step(1, 2, 1, 8, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 3, 1, 8, 0, 0, 0, 0, 1, 0, 0);
        idle(8);

        // Freeze with a MUL at age 2
        step(1, 2, 1, 7, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        repeat (3) step(1, 0, 0, 0, 7, 0, 1, 0, 1, 1, 0);
        repeat (5) step(1, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0);
        idle(3);

        // Reset with four producers pending
        step(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        step(1, 2, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        step(1, 2, 1, 4, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 3, 4, 1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 1, 2, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 3, 4, 1, 1, 1, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 399) == 0);
        end
        idle(2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
